// File: rtl/adc_link_pkg.sv
// Shared constants and types for the ADC-to-host UART framing link.
package adc_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES       = 4;
    localparam int         BITS_PER_BYTE     = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/adc_frame_uart_tx_if.sv
// Sample-in / UART-out signal bundle between the ADC side and the framer.
interface adc_frame_uart_tx_if;

    logic [15:0] sample_in;
    logic        sample_rdy;
    logic        tx;
    logic        busy;
    logic        sample_accept;
    logic        frame_done;

    modport master (
        output sample_in,
        output sample_rdy,
        input  tx,
        input  busy,
        input  sample_accept,
        input  frame_done
    );

    modport slave (
        input  sample_in,
        input  sample_rdy,
        output tx,
        output busy,
        output sample_accept,
        output frame_done
    );

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// o_done is high during the final cycle of the stop bit so the caller can
// strobe the next byte on the same edge, giving back-to-back bytes.
module uart_byte_tx
    import adc_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clkouta,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_start,
    output logic       o_tx,
    output logic       o_done
);

    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_active;
    logic          r_tx;
    logic          w_bit_end;
    logic          w_last;

    assign w_bit_end = (r_cnt == CNT_MAX);
    assign w_last    = r_active && w_bit_end && (r_bit == 4'(BITS_PER_BYTE - 1));

    // Bit timing, shift register and registered line output.
    always_ff @(posedge clkouta) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_active <= 1'b0;
            r_tx     <= 1'b1;
        end else if (i_start) begin
            // Start has priority so a new byte can follow the stop bit directly.
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= {1'b1, i_byte};
            r_active <= 1'b1;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (w_last) begin
                    r_bit    <= '0;
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tx   = r_tx;
    assign o_done = w_last;

endmodule

// File: rtl/adc_frame_uart_tx.sv
// Ships each accepted 16-bit ADC sample as a 4-byte UART frame:
// SYNC, sample[15:8], sample[7:0], sample[15:8]^sample[7:0].
module adc_frame_uart_tx
    import adc_link_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 87,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                      clkouta,
    input  logic                      rst,
    adc_frame_uart_tx_if.slave        bus
);

    seq_state_t  r_state;
    seq_state_t  w_state_next;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_next;
    logic [15:0] r_sample;
    logic        r_accept;
    logic        w_accept;
    logic        w_start;
    logic [1:0]  w_byte_sel;
    logic [7:0]  w_byte;
    logic [7:0]  w_checksum;
    logic        w_tx;
    logic        w_done;

    assign w_checksum = r_sample[15:8] ^ r_sample[7:0];

    // Sequencer next state; the serializer start is issued combinationally so
    // byte 0 begins on the accept edge and later bytes on the previous stop edge.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_byte_sel   = r_idx + 2'd1;
        case (r_state)
            IDLE: begin
                w_byte_sel = 2'd0;
                if (bus.sample_rdy) begin
                    w_accept     = 1'b1;
                    w_start      = 1'b1;
                    w_idx_next   = 2'd0;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_done) begin
                    if (r_idx == 2'(FRAME_BYTES - 1)) begin
                        w_idx_next   = 2'd0;
                        w_state_next = DONE;
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                        w_start    = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = 2'd0;
            end
        endcase
    end

    // Byte mux: selects the byte being handed to the serializer.
    always_comb begin
        w_byte = SYNC_BYTE;
        case (w_byte_sel)
            2'd0:    w_byte = SYNC_BYTE;
            2'd1:    w_byte = r_sample[15:8];
            2'd2:    w_byte = r_sample[7:0];
            default: w_byte = w_checksum;
        endcase
    end

    // Sequencer state, byte index and accept pulse registers.
    always_ff @(posedge clkouta) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= 2'd0;
            r_accept <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_accept <= w_accept;
        end
    end

    // Sample holding register, loaded only on the accept edge.
    always_ff @(posedge clkouta) begin
        if (rst) begin
            r_sample <= '0;
        end else if (w_accept) begin
            r_sample <= bus.sample_in;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clkouta (clkouta),
        .rst     (rst),
        .i_byte  (w_byte),
        .i_start (w_start),
        .o_tx    (w_tx),
        .o_done  (w_done)
    );

    assign bus.tx            = w_tx;
    assign bus.busy          = (r_state != IDLE);
    assign bus.sample_accept = r_accept;
    assign bus.frame_done    = (r_state == DONE);

endmodule

// File: tb/tb_adc_frame_uart_tx.sv
// Directed bench for adc_frame_uart_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_adc_frame_uart_tx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adc_frame_uart_tx_if if4 ();
    adc_frame_uart_tx_if if1 ();

    adc_frame_uart_tx #(
        .CLKS_PER_BIT (4),
        .SYNC_BYTE    (8'hA5)
    ) dut4 (
        .clkouta (clk),
        .rst     (rst),
        .bus     (if4.slave)
    );

    adc_frame_uart_tx #(
        .CLKS_PER_BIT (1),
        .SYNC_BYTE    (8'hA5)
    ) dut1 (
        .clkouta (clk),
        .rst     (rst),
        .bus     (if1.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? if1.tx : if4.tx;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel != 0) ? if1.busy : if4.busy;
    endfunction
    function automatic logic get_acc(input int sel);
        return (sel != 0) ? if1.sample_accept : if4.sample_accept;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel != 0) ? if1.frame_done : if4.frame_done;
    endfunction

    task automatic set_in(input int sel, input logic [15:0] val, input logic rdy);
        if (sel != 0) begin
            if1.sample_in  = val;
            if1.sample_rdy = rdy;
        end else begin
            if4.sample_in  = val;
            if4.sample_rdy = rdy;
        end
    endtask

    task automatic set_val(input int sel, input logic [15:0] val);
        if (sel != 0) if1.sample_in = val;
        else          if4.sample_in = val;
    endtask

    task automatic set_rdy(input int sel, input logic rdy);
        if (sel != 0) if1.sample_rdy = rdy;
        else          if4.sample_rdy = rdy;
    endtask

    task automatic push_frame(input logic [15:0] s);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        exp_q.push_back(s[15:8] ^ s[7:0]);
    endtask

    // Called at a negedge of an IDLE cycle N; returns at the negedge of N+1.
    task automatic start_frame(input int sel, input logic [15:0] s, input logic hold);
        set_in(sel, s, 1'b1);
        push_frame(s);
        @(negedge clk);
        if (!hold) set_rdy(sel, 1'b0);
        check("accept_pulse", get_acc(sel), 1'b1);
        check("busy_start", get_busy(sel), 1'b1);
        check("tx_start_bit", get_tx(sel), 1'b0);
    endtask

    // Entered at negedge of N+1 (first start bit cycle). Returns at the DONE
    // cycle negedge, or right after the reset check when abort_bit is hit.
    task automatic frame_check(input int sel, input int abort_bit,
                               input logic chg, input logic [15:0] chg_val);
        int cpb;
        cpb = (sel != 0) ? 1 : 4;
        for (int b = 0; b < 4; b++) begin
            logic [7:0] e;
            logic [9:0] bits;
            logic [7:0] rx;
            e    = exp_q.pop_front();
            bits = {1'b1, e, 1'b0};
            rx   = 8'h00;
            for (int i = 0; i < 10; i++) begin
                int  k;
                logic ok;
                logic ctr;
                k   = b * 10 + i;
                ok  = 1'b1;
                ctr = 1'b0;
                for (int c = 0; c < cpb; c++) begin
                    if (!(k == 0 && c == 0)) @(negedge clk);
                    if (k == abort_bit && c == 0) begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check("rst_tx_high", get_tx(sel), 1'b1);
                        check("rst_busy_low", get_busy(sel), 1'b0);
                        check("rst_no_done", get_done(sel), 1'b0);
                        exp_q.delete();
                        return;
                    end
                    if (get_tx(sel) !== bits[i] || get_busy(sel) !== 1'b1 ||
                        get_done(sel) !== 1'b0)
                        ok = 1'b0;
                    if (c == cpb / 2) ctr = get_tx(sel);
                end
                if (i >= 1 && i <= 8) rx[i-1] = ctr;
                check($sformatf("bit%0d_held", k), ok, 1'b1);
                if (chg && k == 10) begin
                    set_val(sel, chg_val);
                    push_frame(chg_val);
                end
            end
            check($sformatf("byte%0d", b), rx, e);
        end
        @(negedge clk);
        check("done_pulse", get_done(sel), 1'b1);
        check("done_busy", get_busy(sel), 1'b1);
        check("done_tx", get_tx(sel), 1'b1);
    endtask

    // One cycle after DONE: back in IDLE.
    task automatic idle_check(input int sel);
        @(negedge clk);
        check("idle_busy", get_busy(sel), 1'b0);
        check("idle_tx", get_tx(sel), 1'b1);
        check("idle_done", get_done(sel), 1'b0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        set_in(0, 16'h0000, 1'b0);
        set_in(1, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check("rst4_tx", if4.tx, 1'b1);
        check("rst4_busy", if4.busy, 1'b0);
        check("rst4_acc", if4.sample_accept, 1'b0);
        check("rst4_done", if4.frame_done, 1'b0);
        check("rst1_tx", if1.tx, 1'b1);
        check("rst1_busy", if1.busy, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CPB=4, 0x1234 with one-cycle ready: A5,12,34,26.
        start_frame(0, 16'h1234, 1'b0);
        frame_check(0, -1, 1'b0, 16'h0);
        idle_check(0);
        repeat (3) @(negedge clk);

        start_frame(0, 16'hFFFF, 1'b0);
        frame_check(0, -1, 1'b0, 16'h0);
        idle_check(0);

        start_frame(0, 16'h0000, 1'b0);
        frame_check(0, -1, 1'b0, 16'h0);
        idle_check(0);

        // Ready held high, sample changes mid-frame: frame 2 follows after 2 cycles.
        start_frame(0, 16'h0001, 1'b1);
        frame_check(0, -1, 1'b1, 16'h0002);
        idle_check(0);
        @(negedge clk);
        set_rdy(0, 1'b0);
        check("b2b_accept", get_acc(0), 1'b1);
        check("b2b_start_bit", get_tx(0), 1'b0);
        frame_check(0, -1, 1'b0, 16'h0);
        idle_check(0);

        // Reset at bit 15, then a clean frame.
        start_frame(0, 16'hBEEF, 1'b0);
        frame_check(0, 15, 1'b0, 16'h0);
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (get_done(0) !== 1'b0 || get_busy(0) !== 1'b0 || get_tx(0) !== 1'b1)
                seen = 1'b1;
        end
        check("quiet_after_rst", seen, 1'b0);
        start_frame(0, 16'h4321, 1'b0);
        frame_check(0, -1, 1'b0, 16'h0);
        idle_check(0);

        // CPB=1, 0xA55A: A5,A5,5A,FF in 40 cycles.
        start_frame(1, 16'hA55A, 1'b0);
        frame_check(1, -1, 1'b0, 16'h0);
        idle_check(1);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
